display_channel_sequencer: RTL and testbench
============================================

# display_channel_sequencer

Parametrised, registered N-channel display source selector feeding the seven-segment display driver. It replaces the fixed four-way combinational mux with per-channel decimal-point patterns. It adds:
- a selection register advanced by a button pulse or by an automatic dwell timer;
- a hold mode that freezes the displayed value;
- a one-cycle pulse whenever the displayed channel changes.

## Interface
Parameters:
- N_CH, 4: number of input channels, 2..16.
- DATA_W, 16: width of each channel word.
- DP_W, 4: decimal-point vector width (one bit per digit).
- DWELL_CYCLES, 100_000_000: auto-advance period in clk cycles, ≥2.
- DP_MAP, {4'b0000,4'b0000,4'b1000,4'b0000}: packed N_CH*DP_W decimal-point patterns. Channel k uses DP_MAP[k*DP_W +: DP_W].

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- in_data, in, N_CH*DATA_W: channel words packed; channel k is in_data[k*DATA_W +: DATA_W].
- next_pulse, in, 1: single-cycle request to advance to the next channel (already debounced and edge-detected upstream).
- auto_en, in, 1: level; enables dwell-timer auto-advance.
- hold, in, 1: level; freezes selection and displayed value.
- sel, out, SEL_W = max(1,$clog2(N_CH)): current channel index.
- mux_out, out, DATA_W: registered display word.
- decimal_point, out, DP_W: registered DP pattern of the displayed channel.
- sel_changed, out, 1: one-cycle pulse on the cycle sel takes a new value.

## Operation
- FSM states:
  - MANUAL: hold=0, auto_en=0.
  - AUTO: hold=0, auto_en=1.
  - HOLD: hold=1.
  - State is re-evaluated each cycle from the inputs. HOLD has priority over AUTO, and AUTO over MANUAL.
- Selection (sel):
  - Advance means sel ← (sel == N_CH-1) ? 0 : sel+1. Wrap-around is mandatory and independent of whether N_CH is a power of two.
  - MANUAL: advance on next_pulse.
  - AUTO: advance on next_pulse or on dwell expiry. Both in the same cycle produce exactly one advance.
  - HOLD: next_pulse is ignored and dropped, not queued. No advance occurs.
- Dwell counter (width $clog2(DWELL_CYCLES)):
  - Counts only in AUTO; otherwise it is cleared to 0.
  - Expiry occurs when the counter equals DWELL_CYCLES-1. On expiry the counter returns to 0.
  - next_pulse in AUTO also clears the counter, giving a full dwell after a manual step.
- Output registers:
  - Not HOLD: mux_out ← channel selected by the next-state value of sel; decimal_point ← DP_MAP entry for that channel.
  - HOLD: mux_out and decimal_point keep their values. The live in_data is not sampled.
- sel_changed is 1 for exactly the cycle in which the registered sel differs from its previous value, otherwise 0.
- Out-of-range sel (≥N_CH) is unreachable by construction. If forced, mux_out ← 0 and decimal_point ← 0.

## Timing
- Reset (reset_n=0, asynchronous assert, synchronous release on clk):
  - sel=0, mux_out=0, decimal_point=0, sel_changed=0, dwell counter=0.
  - Reset mid-dwell or mid-hold discards all state.
- First clk edge after release (hold=0): mux_out=in_data ch0, decimal_point=DP_MAP ch0.
- Latency:
  - next_pulse at edge t gives new sel, matching mux_out/decimal_point, and sel_changed=1, all visible after edge t. This is one-cycle latency, with no cycle in which sel and mux_out disagree.
  - in_data change to mux_out: one cycle when not in HOLD.
- AUTO timing:
  - With auto_en held high from edge t0 and no next_pulse, advances occur at edges t0+DWELL_CYCLES, t0+2*DWELL_CYCLES, …
- HOLD timing:
  - Asserting hold at edge t: the value registered at t-1 persists.
  - Deasserting hold: live tracking resumes at the next edge. The dwell counter restarts from 0 if auto_en=1.
- auto_en toggled low then high restarts the dwell from 0.

## Test plan
- Reset/defaults: N_CH=4, in_data ch0=16'h1234, reset_n pulsed low mid-cycle → outputs 0 immediately. After release, one edge later: mux_out=16'h1234, decimal_point=4'b0000, sel=0, sel_changed=0.
- Manual wrap: four next_pulse pulses with ch0..3 = 16'hA000..16'hA003 → sel 1,2,3,0. mux_out follows each one cycle later. decimal_point=4'b1000 only at sel=1. sel_changed high exactly four single cycles.
- Auto dwell: DWELL_CYCLES=8, auto_en=1 → sel advances every 8 cycles. next_pulse at cycle 3 of a dwell gives one immediate advance, and the next auto advance comes 8 cycles after that pulse. next_pulse coincident with expiry → single advance.
- Hold: hold=1 while sel=2, in_data ch2 changed to 16'hBEEF, five next_pulse pulses → sel stays 2, mux_out keeps its old value, sel_changed stays 0. hold=0 → mux_out=16'hBEEF after one edge.
- Non-power-of-two: N_CH=3, DATA_W=12, DP_W=4 → sel sequence 0,1,2,0 under next_pulse. sel never reaches 3. Per-channel DP patterns match DP_MAP.
- Reset mid-AUTO: reset_n asserted at dwell count 5 of 8 → after release, the first auto advance occurs 8 cycles after auto_en is sampled high.

Source files
------------

// File: rtl/display_channel_sequencer.sv
// display_channel_sequencer: registered N-channel source selector for the
// seven-segment driver, with a per-channel decimal-point pattern.
// Selection advances on a button pulse or on a dwell timer; hold freezes the display.
// Latency: one clk from next_pulse/in_data to sel/mux_out/decimal_point/sel_changed.
// Backpressure: none; next_pulse arriving during hold is dropped, not queued.
//
// Ports:
//   clk, reset_n      : clock and asynchronous active-low reset
//   in_data           : N_CH packed channel words; channel k at [k*DATA_W +: DATA_W]
//   next_pulse        : single-cycle advance request
//   auto_en, hold     : mode levels (hold wins over auto_en)
//   sel               : current channel index
//   mux_out           : registered display word
//   decimal_point     : registered DP pattern of the displayed channel
//   sel_changed       : one-cycle pulse when sel takes a new value
module display_channel_sequencer #(
  parameter int N_CH         = 4,
  parameter int DATA_W       = 16,
  parameter int DP_W         = 4,
  parameter int DWELL_CYCLES = 100_000_000,
  parameter logic [N_CH*DP_W-1:0] DP_MAP = {4'b0000, 4'b0000, 4'b1000, 4'b0000},
  localparam int SEL_W       = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic                     next_pulse,
  input  logic                     auto_en,
  input  logic                     hold,
  output logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        mux_out,
  output logic [DP_W-1:0]          decimal_point,
  output logic                     sel_changed
);

  localparam int CNT_W = $clog2(DWELL_CYCLES);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_AUTO   = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t              w_state;
  logic [CNT_W-1:0]    r_dwell;
  logic [SEL_W-1:0]    r_sel;
  logic [DATA_W-1:0]   r_mux;
  logic [DP_W-1:0]     r_dp;
  logic                r_sel_changed;

  logic                w_expire;
  logic                w_advance;
  logic [SEL_W-1:0]    w_sel_inc;
  logic [SEL_W-1:0]    w_sel_nxt;
  logic [DATA_W-1:0]   w_mux_nxt;
  logic [DP_W-1:0]     w_dp_nxt;

  // The operating mode is a pure function of the current inputs, so it is
  // decoded combinationally and acts on the same edge the inputs are sampled.
  always_comb begin
    w_state = ST_MANUAL;
    if (hold) begin
      w_state = ST_HOLD;
    end else if (auto_en) begin
      w_state = ST_AUTO;
    end
  end

  assign w_expire  = (w_state == ST_AUTO) && (r_dwell == CNT_W'(DWELL_CYCLES - 1));
  // A pulse coinciding with expiry still yields a single step.
  assign w_advance = (w_state != ST_HOLD) && (next_pulse || w_expire);
  // Explicit wrap so non-power-of-two channel counts never reach N_CH.
  assign w_sel_inc = (r_sel == SEL_W'(N_CH - 1)) ? '0 : r_sel + SEL_W'(1);
  assign w_sel_nxt = w_advance ? w_sel_inc : r_sel;

  // Output word and DP follow the next-state sel so sel and mux_out never
  // disagree. An index with no matching channel falls through to zero.
  always_comb begin
    w_mux_nxt = '0;
    w_dp_nxt  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_sel_nxt == SEL_W'(k)) begin
        w_mux_nxt = in_data[k*DATA_W +: DATA_W];
        w_dp_nxt  = DP_MAP[k*DP_W +: DP_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dwell       <= '0;
      r_sel         <= '0;
      r_mux         <= '0;
      r_dp          <= '0;
      r_sel_changed <= 1'b0;
    end else begin
      case (w_state)
        ST_AUTO: begin
          // A manual step restarts the dwell so it gets a full period.
          if (next_pulse || w_expire) begin
            r_dwell <= '0;
          end else begin
            r_dwell <= r_dwell + CNT_W'(1);
          end
        end
        default: r_dwell <= '0;
      endcase

      r_sel         <= w_sel_nxt;
      r_sel_changed <= (w_sel_nxt != r_sel);

      if (w_state != ST_HOLD) begin
        r_mux <= w_mux_nxt;
        r_dp  <= w_dp_nxt;
      end
    end
  end

  assign sel           = r_sel;
  assign mux_out       = r_mux;
  assign decimal_point = r_dp;
  assign sel_changed   = r_sel_changed;

endmodule

// File: tb/tb_display_channel_sequencer.sv
// Scoreboard bench for display_channel_sequencer: a 4-channel instance
// (dwell 8) and a 3-channel, 12-bit instance (dwell 6) share the control inputs.
// The driver pushes expected outputs per edge; a monitor pops and compares.
module tb_display_channel_sequencer;

  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] mux;
    logic [3:0]  dp;
    logic        chg;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic next_pulse = 1'b0;
  logic auto_en = 1'b0;
  logic hold = 1'b0;

  logic [15:0] d0 [4];
  logic [11:0] d1 [3];
  logic [63:0] in0;
  logic [35:0] in1;
  assign in0 = {d0[3], d0[2], d0[1], d0[0]};
  assign in1 = {d1[2], d1[1], d1[0]};

  logic [1:0]  sel0;
  logic [15:0] mux0;
  logic [3:0]  dp0;
  logic        chg0;
  logic [1:0]  sel1;
  logic [11:0] mux1;
  logic [3:0]  dp1;
  logic        chg1;

  display_channel_sequencer #(
    .N_CH(4), .DATA_W(16), .DP_W(4), .DWELL_CYCLES(8), .DP_MAP(16'h0080)
  ) u_dut4 (
    .clk(clk), .reset_n(reset_n), .in_data(in0), .next_pulse(next_pulse),
    .auto_en(auto_en), .hold(hold), .sel(sel0), .mux_out(mux0),
    .decimal_point(dp0), .sel_changed(chg0)
  );

  display_channel_sequencer #(
    .N_CH(3), .DATA_W(12), .DP_W(4), .DWELL_CYCLES(6), .DP_MAP(12'h529)
  ) u_dut3 (
    .clk(clk), .reset_n(reset_n), .in_data(in1), .next_pulse(next_pulse),
    .auto_en(auto_en), .hold(hold), .sel(sel1), .mux_out(mux1),
    .decimal_point(dp1), .sel_changed(chg1)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t q [2][$];

  // Reference model: displayed channel index, consecutive AUTO edges since the
  // dwell last restarted, and the values the display should show.
  logic [3:0] dpt0 [4] = '{4'b0000, 4'b1000, 4'b0000, 4'b0000};
  logic [3:0] dpt1 [3] = '{4'b1001, 4'b0010, 4'b0101};
  int          m_sel [2];
  int          m_dw  [2];
  logic [15:0] m_mux [2];
  logic [3:0]  m_dp  [2];
  logic        m_chg [2];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_sel[d] = 0; m_dw[d] = 0; m_mux[d] = '0; m_dp[d] = '0; m_chg[d] = 1'b0;
    end
  endfunction

  function automatic void model_edge(int d, logic np, logic ae, logic hd);
    int   n     = (d == 0) ? 4 : 3;
    int   dwell = (d == 0) ? 8 : 6;
    logic adv;
    if (hd) begin
      m_dw[d]  = 0;
      m_chg[d] = 1'b0;
      return;
    end
    adv = np;
    if (ae) begin
      if (np) begin
        m_dw[d] = 0;
      end else begin
        m_dw[d] = m_dw[d] + 1;
        if (m_dw[d] == dwell) begin
          adv = 1'b1;
          m_dw[d] = 0;
        end
      end
    end else begin
      m_dw[d] = 0;
    end
    if (adv) m_sel[d] = (m_sel[d] + 1) % n;
    m_chg[d] = adv;
    m_mux[d] = (d == 0) ? d0[m_sel[d]] : 16'(d1[m_sel[d]]);
    m_dp[d]  = (d == 0) ? dpt0[m_sel[d]] : dpt1[m_sel[d]];
  endfunction

  function automatic exp_t actual(int d);
    exp_t a;
    if (d == 0) begin
      a.sel = 4'(sel0); a.mux = mux0; a.dp = dp0; a.chg = chg0;
    end else begin
      a.sel = 4'(sel1); a.mux = 16'(mux1); a.dp = dp1; a.chg = chg1;
    end
    return a;
  endfunction

  function automatic void check(string nm, exp_t a, exp_t e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got sel=%0d mux=%h dp=%b chg=%b, expected sel=%0d mux=%h dp=%b chg=%b",
               nm, $time, a.sel, a.mux, a.dp, a.chg, e.sel, e.mux, e.dp, e.chg);
    end
  endfunction

  // Called at a falling edge; drives one cycle of inputs and records the
  // expected outputs after the following rising edge.
  task automatic step(input logic np, input logic ae, input logic hd);
    exp_t e;
    next_pulse = np;
    auto_en    = ae;
    hold       = hd;
    for (int d = 0; d < 2; d++) begin
      model_edge(d, np, ae, hd);
      e.sel = 4'(m_sel[d]); e.mux = m_mux[d]; e.dp = m_dp[d]; e.chg = m_chg[d];
      q[d].push_back(e);
    end
    @(negedge clk);
  endtask

  // Asserts reset in mid-cycle, checks outputs clear immediately, releases
  // at the next falling edge and returns there.
  task automatic do_reset();
    @(posedge clk);
    #3;
    reset_n    = 1'b0;
    next_pulse = 1'b0;
    auto_en    = 1'b0;
    hold       = 1'b0;
    #1;
    check("reset_dut4", actual(0), '0);
    check("reset_dut3", actual(1), '0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // Monitor: every rising edge with a pending expectation is compared.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q[0].size() > 0) check("cycle_dut4", actual(0), q[0].pop_front());
      if (q[1].size() > 0) check("cycle_dut3", actual(1), q[1].pop_front());
    end
  end

  initial begin
    logic ae;
    logic hd;
    d0 = '{16'h1234, 16'h1111, 16'h2222, 16'h3333};
    d1 = '{12'h123, 12'h456, 12'h789};
    model_reset();
    @(negedge clk);
    do_reset();
    step(0, 0, 0);
    step(0, 0, 0);

    // Manual stepping with wrap-around on both channel counts.
    d0 = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    d1 = '{12'hA00, 12'hA01, 12'hA02};
    repeat (4) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end

    // Auto dwell, mid-dwell manual step, step coincident with expiry.
    repeat (18) step(0, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    repeat (7) step(0, 1, 0);
    step(1, 1, 0);
    repeat (10) step(0, 1, 0);
    step(0, 0, 0);
    repeat (3) step(0, 1, 0);
    step(0, 0, 0);
    repeat (9) step(0, 1, 0);

    // Hold freezes sel and display while input changes and pulses arrive.
    do_reset();
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 1);
    d0[2] = 16'hBEEF;
    d1[2] = 12'hBEE;
    repeat (5) begin
      step(1, 0, 1);
      step(0, 0, 1);
    end
    step(0, 0, 0);
    step(0, 0, 0);
    repeat (5) step(0, 1, 0);
    repeat (4) step(0, 1, 1);
    repeat (10) step(0, 1, 0);

    // Reset in the middle of a dwell discards the partial count.
    do_reset();
    repeat (5) step(0, 1, 0);
    do_reset();
    repeat (12) step(0, 1, 0);

    // Randomised traffic.
    ae = 1'b0;
    hd = 1'b0;
    repeat (600) begin
      if ($urandom_range(0, 7) == 0) d0[$urandom_range(0, 3)] = 16'($urandom);
      if ($urandom_range(0, 7) == 0) d1[$urandom_range(0, 2)] = 12'($urandom);
      if ($urandom_range(0, 19) == 0) ae = ~ae;
      if ($urandom_range(0, 24) == 0) hd = ~hd;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end
      step(($urandom_range(0, 4) == 0), ae, hd);
    end
    step(0, 0, 0);

    @(posedge clk);
    #3;
    n_tests++;
    if (q[0].size() != 0 || q[1].size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending expectations, expected 0/0",
               q[0].size(), q[1].size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
